// File: rtl/immgen_if.sv
// Handshake bundle for the immediate-generation stage: instruction/tag in,
// registered immediate/format/tag out.
interface immgen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // master: fetch side plus downstream consumer; slave: the stage itself
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/immgen_stage.sv
// RISC-V immediate generator: combinational decode of every base-ISA
// immediate format followed by a single-entry valid/ready slice with flush.
module immgen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    immgen_if.slave   bus
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [31:0]      instr;
    logic [31:0]      imm32_d;
    logic [XLEN-1:0]  imm_d;
    fmt_e             fmt_d;
    logic             illegal_d;
    logic             accept;

    logic             valid_q;
    logic [XLEN-1:0]  imm_q;
    fmt_e             fmt_q;
    logic             illegal_q;
    logic [TAG_W-1:0] tag_q;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Every format is built as a signed 32-bit value first; the shift amount
    // keeps its top bit clear so the widening below zero-extends it.
    always_comb begin
        imm32_d   = '0;
        fmt_d     = FMT_NONE;
        illegal_d = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm32_d = {{20{instr[31]}}, instr[31:20]};
                fmt_d   = FMT_I;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm32_d = (XLEN == 64) ? {26'b0, instr[25:20]}
                                           : {27'b0, instr[24:20]};
                    fmt_d   = FMT_SHAMT;
                end else begin
                    imm32_d = {{20{instr[31]}}, instr[31:20]};
                    fmt_d   = FMT_I;
                end
            end
            OPC_STORE: begin
                imm32_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_d   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32_d = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
                fmt_d   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32_d = {instr[31:12], 12'b0};
                fmt_d   = FMT_U;
            end
            OPC_JAL: begin
                imm32_d = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
                fmt_d   = FMT_J;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    assign imm_d = XLEN'($signed(imm32_d));

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Priority: reset, then flush, then fill, then drain; data only moves on fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            fmt_q     <= FMT_NONE;
            illegal_q <= 1'b0;
            tag_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
            tag_q     <= bus.in_tag;
        end else if (bus.out_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_illegal = illegal_q;
    assign bus.out_tag     = tag_q;

endmodule
